// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing a 16 x 8-bit register file with a local CPU port
`timescale 1ns/1ps
module i2c_target_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [3:0] loc_addr,
    input  logic [7:0] loc_wdata,
    input  logic       loc_we,
    output logic [7:0] loc_rdata,
    output logic       wr_strobe,
    output logic [3:0] wr_index,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t     state;
    logic [7:0] regs [16];
    logic [7:0] shift;
    logic [3:0] ptr;
    logic [2:0] bitcnt;
    logic       rw;
    logic       ack_drive;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;

    logic       scl_rise, scl_fall, start_cond, stop_cond;
    logic [7:0] rx_byte;

    assign scl_rise   = scl_s2 & ~scl_d;
    assign scl_fall   = ~scl_s2 & scl_d;
    assign start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign rx_byte    = {shift[6:0], sda_s2};
    assign loc_rdata  = regs[loc_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= 4'd0;
            ptr       <= 4'd0;
            bitcnt    <= 3'd0;
            shift     <= 8'h00;
            rw        <= 1'b0;
            ack_drive <= 1'b0;
            scl_s1    <= 1'b1;
            scl_s2    <= 1'b1;
            scl_d     <= 1'b1;
            sda_s1    <= 1'b1;
            sda_s2    <= 1'b1;
            sda_d     <= 1'b1;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            scl_s1    <= scl;
            scl_s2    <= scl_s1;
            scl_d     <= scl_s2;
            sda_s1    <= sda_in;
            sda_s2    <= sda_s1;
            sda_d     <= sda_s2;
            wr_strobe <= 1'b0;

            if (start_cond) begin
                state     <= ADDR;
                bitcnt    <= 3'd0;
                sda_oe    <= 1'b0;
                ack_drive <= 1'b0;
            end else if (stop_cond) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                ack_drive <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift  <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                rw    <= rx_byte[0];
                                busy  <= 1'b1;
                                state <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    // First fall after the 8th bit starts the ACK, the second one ends it.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!ack_drive) begin
                            sda_oe    <= 1'b1;
                            ack_drive <= 1'b1;
                        end else begin
                            ack_drive <= 1'b0;
                            bitcnt    <= 3'd0;
                            if (state == ADDR_ACK && rw) begin
                                shift  <= regs[ptr];
                                sda_oe <= ~regs[ptr][7];
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (state == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                    PTR: if (scl_rise) begin
                        shift  <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            ptr   <= rx_byte[3:0];
                            state <= PTR_ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shift  <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            regs[ptr] <= rx_byte;
                            wr_strobe <= 1'b1;
                            wr_index  <= ptr;
                            ptr       <= ptr + 4'd1;
                            state     <= WDATA_ACK;
                        end
                    end
                    // bitcnt wraps to 0 after the 8th rise; the following fall hands SDA to the master.
                    RDATA: begin
                        if (scl_rise) begin
                            bitcnt <= bitcnt + 3'd1;
                        end else if (scl_fall) begin
                            if (bitcnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= RDATA_ACK;
                            end else begin
                                shift  <= {shift[6:0], 1'b0};
                                sda_oe <= ~shift[6];
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_s2) state <= IGNORE;
                            else        ptr   <= ptr + 4'd1;
                        end else if (scl_fall) begin
                            shift  <= regs[ptr];
                            sda_oe <= ~regs[ptr][7];
                            bitcnt <= 3'd0;
                            state  <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end

            // Placed after the bus write so the local port wins a same-cycle collision.
            if (loc_we) regs[loc_addr] <= loc_wdata;
        end
    end
endmodule
